// File: rtl/alu_seq.sv
// alu_seq: multi-cycle LC3-style ALU with valid/ready handshakes and registered NZP/V flags.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier for op 110.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       nzp,
  output logic             v
);

  localparam int M = WIDTH - 1;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam int CW = $clog2(WIDTH + 1);
`else
  localparam int CW = SHW;
`endif

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           r_state, w_next_state;
  logic [2:0]       r_op, w_op;
  logic [WIDTH-1:0] r_work, w_work;
  logic [CW-1:0]    r_cnt, w_cnt;
`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] r_mplr, w_mplr;
  logic [WIDTH-1:0] r_acc, w_acc;
`endif
  logic [WIDTH-1:0] r_result, w_res;
  logic [2:0]       r_nzp, w_nzp;
  logic             r_v, w_v;
  logic             w_load, w_fire, w_is_shift;
  logic [WIDTH-1:0] w_sum, w_diff;
  logic [SHW-1:0]   w_shamt;

  assign in_ready   = (r_state == IDLE) && !rst;
  assign out_valid  = (r_state == DONE);
  assign result     = r_result;
  assign nzp        = r_nzp;
  assign v          = r_v;
  assign w_fire     = in_valid && in_ready;
  assign w_shamt    = b[SHW-1:0];
  assign w_sum      = a + b;
  assign w_diff     = a - b;
  assign w_is_shift = (op == OP_SHL) || (op == OP_SHR);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Results are only committed (w_load) on the final step, so a partial value never reaches result.
  always_comb begin
    w_next_state = r_state;
    w_op         = r_op;
    w_work       = r_work;
    w_cnt        = r_cnt;
`ifdef ALU_SEQ_MUL_EN
    w_mplr       = r_mplr;
    w_acc        = r_acc;
`endif
    w_load       = 1'b0;
    w_res        = '0;
    w_v          = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fire) begin
          w_op = op;
          if (w_is_shift && (w_shamt != '0)) begin
            w_work       = a;
            w_cnt        = CW'(w_shamt);
            w_next_state = EXEC;
          end
`ifdef ALU_SEQ_MUL_EN
          else if (op == OP_MUL) begin
            w_work       = a;
            w_mplr       = b;
            w_acc        = '0;
            w_cnt        = CW'(WIDTH);
            w_next_state = EXEC;
          end
`endif
          else begin
            w_load       = 1'b1;
            w_next_state = DONE;
            case (op)
              OP_AND:         w_res = a & b;
              OP_NOT:         w_res = ~a;
              OP_SUB: begin
                w_res = w_diff;
                w_v   = (a[M] != b[M]) && (w_diff[M] != a[M]);
              end
              OP_SHL, OP_SHR: w_res = a;
              default: begin
                w_res = w_sum;
                w_v   = (a[M] == b[M]) && (w_sum[M] != a[M]);
              end
            endcase
          end
        end
      end
      EXEC: begin
        w_cnt = r_cnt - CW'(1);
        if (r_op == OP_SHR) w_work = {r_work[M], r_work[M:1]};
        else                w_work = r_work << 1;
`ifdef ALU_SEQ_MUL_EN
        if (r_op == OP_MUL) begin
          w_acc  = r_acc + (r_mplr[0] ? r_work : '0);
          w_mplr = r_mplr >> 1;
        end
`endif
        if (r_cnt == CW'(1)) begin
          w_load       = 1'b1;
          w_next_state = DONE;
`ifdef ALU_SEQ_MUL_EN
          w_res = (r_op == OP_MUL) ? w_acc : w_work;
`else
          w_res = w_work;
`endif
        end
      end
      DONE: begin
        if (out_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    if (w_res[M])          w_nzp = 3'b100;
    else if (w_res == '0)  w_nzp = 3'b010;
    else                   w_nzp = 3'b001;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= '0;
      r_work   <= '0;
      r_cnt    <= '0;
`ifdef ALU_SEQ_MUL_EN
      r_mplr   <= '0;
      r_acc    <= '0;
`endif
      r_result <= '0;
      r_nzp    <= 3'b010;
      r_v      <= 1'b0;
    end else begin
      r_op   <= w_op;
      r_work <= w_work;
      r_cnt  <= w_cnt;
`ifdef ALU_SEQ_MUL_EN
      r_mplr <= w_mplr;
      r_acc  <= w_acc;
`endif
      if (w_load) begin
        r_result <= w_res;
        r_nzp    <= w_nzp;
        r_v      <= w_v;
      end
    end
  end

endmodule
